// File: rtl/rgb_window_filter.sv
// rgb_window_filter: per-channel threshold/window classifier for RGB565 pixels with an output FIFO
// Ports:
//   clock, resetn            sole clock, async active-low reset
//   frame_start              loads bounds/mode into shadow registers, clears match_count/overflow
//   red/green/blue_lo/_hi    6-bit window bounds (R and B are zero-extended to 6 bits)
//   mode                     per channel (bit0=R, bit1=G, bit2=B): 0 = x>=lo, 1 = lo<=x<=hi
//   addr_in, d_in, we_in     frame-grabber write port; a rising edge of we_in marks a pixel
//   addr_out, d_out          FIFO head address and pass flags, zero while empty
//   out_valid, out_ready     FIFO handshake
//   match_count              saturating count of pixels this frame with all three flags set
//   overflow                 sticky, a pixel was dropped this frame
module rgb_window_filter #(
  parameter int ADDR_W = 18,
  parameter int FIFO_DEPTH = 8,
  parameter int THR_RST = 20
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              frame_start,
  input  logic [5:0]        red_lo,
  input  logic [5:0]        red_hi,
  input  logic [5:0]        green_lo,
  input  logic [5:0]        green_hi,
  input  logic [5:0]        blue_lo,
  input  logic [5:0]        blue_hi,
  input  logic [2:0]        mode,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [15:0]       d_in,
  input  logic              we_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic [2:0]        d_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   match_count,
  output logic              overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] ptr_one = 1;
  localparam logic [ADDR_W:0] cnt_one = 1;
  logic we_q, pix, hit, push, pop, wr, drop, full;
  logic [5:0] rl, rh, gl, gh, bl, bh;
  logic [2:0] md, flags, s1_flags;
  logic s1_v;
  logic [ADDR_W-1:0] s1_addr;
  logic [AW:0] wp, rp;
  logic [ADDR_W+2:0] mem [FIFO_DEPTH];
  logic [ADDR_W+2:0] head;
  function automatic logic chan(input logic [5:0] x, input logic [5:0] lo, input logic [5:0] hi, input logic win);
    return win ? (x >= lo && x <= hi) : (x >= lo);
  endfunction
  // Compares always use the shadow values, so a pixel coinciding with frame_start sees the old frame's bounds
  always_comb begin
    pix = we_in & ~we_q;
    flags = {chan({1'b0, d_in[4:0]}, bl, bh, md[2]),
             chan(d_in[10:5], gl, gh, md[1]),
             chan({1'b0, d_in[15:11]}, rl, rh, md[0])};
    hit = pix && flags == 3'b111;
    full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    out_valid = wp != rp;
    push = s1_v;
    pop = out_valid & out_ready;
    wr = push & (~full | pop);
    drop = push & full & ~pop;
    head = mem[rp[AW-1:0]];
    addr_out = out_valid ? head[ADDR_W+2:3] : '0;
    d_out = out_valid ? head[2:0] : '0;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      we_q <= 1'b0;
      {rl, gl, bl} <= {3{6'(THR_RST)}};
      {rh, gh, bh} <= {3{6'h3F}};
      md <= 3'b000;
      s1_v <= 1'b0;
      s1_addr <= '0;
      s1_flags <= '0;
      wp <= '0;
      rp <= '0;
      match_count <= '0;
      overflow <= 1'b0;
    end else begin
      we_q <= we_in;
      if (frame_start) begin
        {rl, rh, gl, gh, bl, bh} <= {red_lo, red_hi, green_lo, green_hi, blue_lo, blue_hi};
        md <= mode;
      end
      s1_v <= pix;
      if (pix) begin
        s1_addr <= addr_in;
        s1_flags <= flags;
      end
      if (wr) wp <= wp + ptr_one;
      if (pop) rp <= rp + ptr_one;
      if (frame_start) match_count <= {{ADDR_W{1'b0}}, hit};
      else if (hit && !(&match_count)) match_count <= match_count + cnt_one;
      overflow <= frame_start ? 1'b0 : (overflow | drop);
    end
  end
  always_ff @(posedge clock) begin
    if (wr) mem[wp[AW-1:0]] <= {s1_addr, s1_flags};
  end
endmodule
